// File: rtl/axi_stream_remove_header.sv
// AXI-Stream header stripper: drops the first N bytes of each packet, realigns the
// payload to the MSB lane and reports the stripped beat once on a header side-port.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_strip,
  input  logic [CNT_WD-1:0]       strip_cnt,
  output logic                    ready_strip,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr
);

  localparam int W = DATA_BYTE_WD;

  // One extra bit so byte totals up to 2W fit.
  typedef logic [CNT_WD:0] cnt_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic logic [W-1:0] msb_ones(input cnt_t c);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++)
      if (cnt_t'(i) < c) m[W-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [W-1:0] k);
    logic [DATA_WD-1:0] e;
    for (int i = 0; i < W; i++) e[8*i +: 8] = {8{k[i]}};
    return e;
  endfunction

  // Bytes n..n+W-1 of {hi, lo}, byte 0 being the MSB of hi.
  function automatic logic [DATA_WD-1:0] window(input logic [DATA_WD-1:0] hi,
                                                input logic [DATA_WD-1:0] lo,
                                                input cnt_t n);
    logic [2*DATA_WD-1:0] w;
    w = {hi, lo} << {n, 3'b000};
    return w[2*DATA_WD-1 -: DATA_WD];
  endfunction

  state_t              state_q, state_d;
  cnt_t                n_q, n_d;
  logic                first_q, first_d;
  logic [DATA_WD-1:0]  prev_q, prev_d;
  cnt_t                flush_q, flush_d;
  logic                valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]  data_out_q, data_out_d;
  logic [W-1:0]        keep_out_q, keep_out_d;
  logic                last_out_q, last_out_d;
  logic                valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0]  data_hdr_q, data_hdr_d;
  logic [W-1:0]        keep_hdr_q, keep_hdr_d;

  logic                rdy_strip_c, rdy_in_c, out_en;
  logic                load, ld_last;
  logic [DATA_WD-1:0]  ld_data;
  cnt_t                ld_cnt, k_in, total, strip_n;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    first_d     = first_q;
    prev_d      = prev_q;
    flush_d     = flush_q;
    valid_out_d = valid_out_q & ~ready_out;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    valid_hdr_d = 1'b0;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    rdy_strip_c = 1'b0;
    rdy_in_c    = 1'b0;
    load        = 1'b0;
    ld_data     = '0;
    ld_cnt      = '0;
    ld_last     = 1'b0;

    out_en  = ~valid_out_q | ready_out;
    strip_n = (cnt_t'(strip_cnt) > cnt_t'(W)) ? cnt_t'(W) : cnt_t'(strip_cnt);

    // Non-last beats are full regardless of keep_in.
    k_in = '0;
    for (int i = 0; i < W; i++) k_in = k_in + cnt_t'(keep_in[i]);
    if (!last_in) k_in = cnt_t'(W);
    total = cnt_t'(W) - n_q + k_in;

    case (state_q)
      IDLE: begin
        // Wait for the last output beat to drain before taking a new packet.
        rdy_strip_c = ~valid_out_q;
        if (valid_strip && rdy_strip_c) begin
          n_d     = strip_n;
          first_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        rdy_in_c = out_en;
        if (valid_in && rdy_in_c) begin
          prev_d = data_in;
          if (first_q) begin
            first_d     = 1'b0;
            data_hdr_d  = data_in;
            keep_hdr_d  = msb_ones(n_q);
            valid_hdr_d = (n_q != '0);
            if (last_in) begin
              state_d = IDLE;
              if (k_in > n_q) begin
                load    = 1'b1;
                ld_data = window(data_in, '0, n_q);
                ld_cnt  = k_in - n_q;
                ld_last = 1'b1;
              end
            end
          end else if (!last_in || total > cnt_t'(W)) begin
            load    = 1'b1;
            ld_data = window(prev_q, data_in, n_q);
            ld_cnt  = cnt_t'(W);
            if (last_in) begin
              flush_d = total - cnt_t'(W);
              state_d = FLUSH;
            end
          end else begin
            load    = 1'b1;
            ld_data = window(prev_q, data_in, n_q);
            ld_cnt  = total;
            ld_last = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (out_en) begin
          load    = 1'b1;
          ld_data = window(prev_q, '0, n_q);
          ld_cnt  = flush_q;
          ld_last = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lanes beyond the byte count are forced to zero.
    if (load) begin
      valid_out_d = 1'b1;
      keep_out_d  = msb_ones(ld_cnt);
      data_out_d  = ld_data & expand(msb_ones(ld_cnt));
      last_out_d  = ld_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      first_q     <= 1'b0;
      prev_q      <= '0;
      flush_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      valid_hdr_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      first_q     <= first_d;
      prev_q      <= prev_d;
      flush_q     <= flush_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      valid_hdr_q <= valid_hdr_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign ready_strip = rst_n & rdy_strip_c;
  assign ready_in    = rst_n & rdy_in_c;
  assign valid_out   = valid_out_q;
  assign data_out    = data_out_q;
  assign keep_out    = keep_out_q;
  assign last_out    = last_out_q;
  assign valid_hdr   = valid_hdr_q;
  assign data_hdr    = data_hdr_q;
  assign keep_hdr    = keep_hdr_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Bench for axi_stream_remove_header: packets are modelled as byte lists, the
// expected output is the byte list minus its header re-chunked into beats.
module tb_axi_stream_remove_header;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_strip;
  logic [CW-1:0] strip_cnt;
  logic          ready_strip;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [W-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [W-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_hdr;
  logic [DW-1:0] data_hdr;
  logic [W-1:0]  keep_hdr;

  axi_stream_remove_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_strip(valid_strip), .strip_cnt(strip_cnt), .ready_strip(ready_strip),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    logic          l;
  } beat_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_packet(input int n_strip, input int nbytes, input int rdy_pct);
    byte unsigned  pkt[$];
    logic [DW-1:0] in_d[$];
    logic [W-1:0]  in_k[$];
    beat_t         expq[$];
    beat_t         bt, held;
    logic [W-1:0]  kh;
    int n, beats, bi, cyc, idle_cnt, hdr_pulses, t;
    logic stalled, in_acc;

    n     = (n_strip > W) ? W : n_strip;
    beats = (nbytes + W - 1) / W;
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));

    for (int b = 0; b < beats; b++) begin
      bt.d = '0; bt.k = '0;
      for (int l = 0; l < W; l++) begin
        if (b*W + l < nbytes) begin
          bt.d[DW-1-8*l -: 8] = pkt[b*W + l];
          bt.k[W-1-l] = 1'b1;
        end else begin
          bt.d[DW-1-8*l -: 8] = 8'($urandom);
        end
      end
      in_d.push_back(bt.d);
      in_k.push_back(bt.k);
    end

    for (int p = n; p < nbytes; p += W) begin
      bt.d = '0; bt.k = '0;
      for (int l = 0; l < W; l++)
        if (p + l < nbytes) begin
          bt.d[DW-1-8*l -: 8] = pkt[p + l];
          bt.k[W-1-l] = 1'b1;
        end
      bt.l = (p + W >= nbytes);
      expq.push_back(bt);
    end
    kh = '0;
    for (int l = 0; l < n; l++) kh[W-1-l] = 1'b1;

    @(negedge clk);
    ready_out   = 1'b1;
    valid_strip = 1'b1;
    strip_cnt   = CW'(n_strip);
    #1;
    t = 0;
    while (!ready_strip && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check("strip_ready", ready_strip, 1);
    @(posedge clk);
    @(negedge clk);
    valid_strip = 1'b0;
    #1;
    check("ready_in_after_strip", ready_in, 1);

    bi = 0; cyc = 0; idle_cnt = 0; hdr_pulses = 0; stalled = 1'b0;
    held = '{d: '0, k: '0, l: 1'b0};
    while (cyc < 2000) begin
      @(negedge clk);
      ready_out = ($urandom_range(0, 99) < rdy_pct);
      valid_in  = (bi < beats) && ($urandom_range(0, 3) != 0);
      if (bi < beats) begin
        data_in = in_d[bi];
        keep_in = in_k[bi];
        last_in = (bi == beats - 1);
      end
      #1;
      if (stalled) begin
        check("stall_valid", valid_out, 1);
        check("stall_data", data_out, held.d);
        check("stall_keep", keep_out, held.k);
        check("stall_last", last_out, held.l);
      end
      if (valid_hdr) begin
        hdr_pulses++;
        check("data_hdr", data_hdr, in_d[0]);
        check("keep_hdr", keep_hdr, kh);
      end
      if (valid_out && ready_out) begin
        check("out_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          bt = expq.pop_front();
          check("out_data", data_out, bt.d);
          check("out_keep", keep_out, bt.k);
          check("out_last", last_out, bt.l);
        end
      end
      stalled = valid_out && !ready_out;
      held    = '{d: data_out, k: keep_out, l: last_out};
      in_acc  = valid_in && ready_in;
      @(posedge clk);
      if (in_acc) bi++;
      cyc++;
      if (bi == beats && expq.size() == 0) idle_cnt++;
      if (idle_cnt > 3) break;
    end
    check("packet_drained", (bi == beats) && (expq.size() == 0), 1);
    check("hdr_pulses", hdr_pulses, (n > 0) ? 1 : 0);
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    #1;
    check("idle_ready_strip", ready_strip, 1);
    check("idle_valid_out", valid_out, 0);
  endtask

  initial begin
    rst_n = 1'b0; valid_strip = 1'b0; strip_cnt = '0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; ready_out = 1'b0;

    @(negedge clk); #1;
    check("rst_ready_strip", ready_strip, 0);
    check("rst_ready_in", ready_in, 0);
    @(posedge clk); #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_keep_out", keep_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_valid_hdr", valid_hdr, 0);
    check("rst_data_hdr", data_hdr, 0);
    check("rst_keep_hdr", keep_hdr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready_in", ready_in, 0);

    run_packet(1, 14, 100);
    run_packet(2, 6, 100);
    run_packet(3, 3, 100);
    run_packet(0, 24, 50);
    run_packet(4, 9, 100);

    // Reset in the middle of an N=1 packet.
    @(negedge clk);
    ready_out = 1'b1; valid_strip = 1'b1; strip_cnt = 3'd1;
    @(posedge clk);
    @(negedge clk);
    valid_strip = 1'b0;
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF; last_in = 1'b0;
    #1;
    check("mid_ready_in0", ready_in, 1);
    @(posedge clk);
    @(negedge clk);
    data_in = 32'h55667788;
    #1;
    check("mid_ready_in1", ready_in, 1);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("mid_out_before_rst", data_out, 32'h22334455);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_in", ready_in, 0);
    check("mid_rst_ready_strip", ready_strip, 0);
    @(posedge clk); #1;
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_data_hdr", data_hdr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_idle", ready_strip, 1);
    run_packet(1, 9, 100);

    for (int i = 0; i < 20; i++)
      run_packet($urandom_range(0, 7), $urandom_range(1, 20), $urandom_range(30, 100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
